laplace_window_gen: RTL and testbench

Streaming neighbourhood generator placed directly upstream of the `laplace9_aprox_3` filter core. It accepts an 8-bit greyscale image in raster order, one pixel per handshake, and buffers two image rows. For every interior pixel it presents the 5-point cross neighbourhood (b, d, e, f, h) on the filter inputs. Per frame it emits (IMG_H-2)·(IMG_W-2) windows in raster order of their centres, which is 510×510 for the default 512×512 image.

---
 rtl/laplace_window_gen_pkg.sv | 14 +
 rtl/laplace_window_gen_if.sv | 31 +++
 rtl/laplace_window_gen_line_buffer.sv | 23 ++
 rtl/laplace_window_gen.sv | 131 +++++++++++++
 tb/tb_laplace_window_gen.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/laplace_window_gen_pkg.sv
// laplace_window_gen shared package.
// Default geometry and derived sizes.
package laplace_pkg;

  localparam int PIX_W = 8;
  localparam int IMG_W = 512;
  localparam int IMG_H = 512;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam int WIN_PER_FRAME = (IMG_H - 2) * (IMG_W - 2);

endpackage

// File: rtl/laplace_window_gen_if.sv
// laplace_window_gen stream interface.
// Pixel input plus cross-window output handshake.
interface laplace_window_gen_if #(
  parameter int PIX_W = laplace_pkg::PIX_W
);

  logic             in_valid;
  logic [PIX_W-1:0] in_pixel;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] b;
  logic [PIX_W-1:0] d;
  logic [PIX_W-1:0] e;
  logic [PIX_W-1:0] f;
  logic [PIX_W-1:0] h;
  logic             out_last;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid,
    input  b, d, e, f, h, out_last
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid,
    output b, d, e, f, h, out_last
  );

endinterface

// File: rtl/laplace_window_gen_line_buffer.sv
// line_buffer: circular one-row delay.
// Read returns the old word at addr; write lands on the clock edge.
module line_buffer #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Contents are never cleared; windows are gated by position.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/laplace_window_gen.sv
// laplace_window_gen: raster stream to 5-point cross windows.
// Two row buffers plus taps feed a single registered output stage.
module laplace_window_gen
  import laplace_pkg::*;
#(
  parameter int IMG_W = laplace_pkg::IMG_W,
  parameter int IMG_H = laplace_pkg::IMG_H,
  parameter int PIX_W = laplace_pkg::PIX_W
) (
  input logic                clk,
  input logic                rst_n,
  laplace_window_gen_if.slave io
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             col_end;
  logic             row_end;
  logic             rdy;
  logic             acc;
  logic             win;

  logic [PIX_W-1:0] lb1_q;
  logic [PIX_W-1:0] lb2_q;
  logic [PIX_W-1:0] cur_d1;
  logic [PIX_W-1:0] r1_d1;
  logic [PIX_W-1:0] r1_d2;
  logic [PIX_W-1:0] r2_d1;

  logic             vld_q;
  logic             last_q;
  logic [PIX_W-1:0] b_q;
  logic [PIX_W-1:0] d_q;
  logic [PIX_W-1:0] e_q;
  logic [PIX_W-1:0] f_q;
  logic [PIX_W-1:0] h_q;

  assign col_end = (col == CW'(IMG_W - 1));
  assign row_end = (row == RW'(IMG_H - 1));
  assign rdy     = !vld_q || io.out_ready;
  assign acc     = io.in_valid && rdy;
  assign win     = acc && (row >= RW'(2)) && (col >= CW'(2));

  assign io.in_ready  = rdy;
  assign io.out_valid = vld_q;
  assign io.out_last  = last_q;
  assign io.b         = b_q;
  assign io.d         = d_q;
  assign io.e         = e_q;
  assign io.f         = f_q;
  assign io.h         = h_q;

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) lb1 (
    .clk   (clk),
    .we    (acc),
    .addr  (col),
    .wdata (io.in_pixel),
    .rdata (lb1_q)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) lb2 (
    .clk   (clk),
    .we    (acc),
    .addr  (col),
    .wdata (lb1_q),
    .rdata (lb2_q)
  );

  // Raster position of the pixel being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Horizontal taps behind the current pixel and the two buffered rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_d1 <= '0;
      r1_d1  <= '0;
      r1_d2  <= '0;
      r2_d1  <= '0;
    end else if (acc) begin
      cur_d1 <= io.in_pixel;
      r1_d1  <= lb1_q;
      r1_d2  <= r1_d1;
      r2_d1  <= lb2_q;
    end
  end

  // Output window register: load on a window, drop valid on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      b_q    <= '0;
      d_q    <= '0;
      e_q    <= '0;
      f_q    <= '0;
      h_q    <= '0;
    end else if (win) begin
      vld_q  <= 1'b1;
      last_q <= row_end && col_end;
      b_q    <= r2_d1;
      d_q    <= r1_d2;
      e_q    <= r1_d1;
      f_q    <= lb1_q;
      h_q    <= cur_d1;
    end else if (io.out_ready) begin
      vld_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_laplace_window_gen.sv
// tb_laplace_window_gen: directed 4x4 cases plus random 8x6 frames.
// Expected windows come from an image-array reference model.
module tb_laplace_window_gen;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] f;
    logic [7:0] h;
    logic       last;
  } win_t;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  logic [7:0] pix_q[$];
  win_t       exp_q[$];
  win_t       got_q[$];

  laplace_window_gen_if #(.PIX_W(8)) s_if ();
  laplace_window_gen_if #(.PIX_W(8)) r_if ();

  win_t win_s;
  win_t win_r;

  assign win_s = {s_if.b, s_if.d, s_if.e, s_if.f, s_if.h, s_if.out_last};
  assign win_r = {r_if.b, r_if.d, r_if.e, r_if.f, r_if.h, r_if.out_last};

  laplace_window_gen #(
    .IMG_W (4),
    .IMG_H (4),
    .PIX_W (8)
  ) u_s (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (s_if)
  );

  laplace_window_gen #(
    .IMG_W (8),
    .IMG_H (6),
    .PIX_W (8)
  ) u_r (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (r_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input logic [7:0] p,
                       input bit rd);
    if (sel) begin
      r_if.in_valid  = v;
      r_if.in_pixel  = p;
      r_if.out_ready = rd;
    end else begin
      s_if.in_valid  = v;
      s_if.in_pixel  = p;
      s_if.out_ready = rd;
    end
  endtask

  function automatic bit ovld(input bit sel);
    return sel ? r_if.out_valid : s_if.out_valid;
  endfunction

  // Reference: every interior centre of a w x h frame at pix_q[off].
  task automatic model(input int w, input int h, input int off);
    win_t x;
    for (int r = 1; r <= h - 2; r++) begin
      for (int c = 1; c <= w - 2; c++) begin
        x.b    = pix_q[off + (r - 1) * w + c];
        x.d    = pix_q[off + r * w + c - 1];
        x.e    = pix_q[off + r * w + c];
        x.f    = pix_q[off + r * w + c + 1];
        x.h    = pix_q[off + (r + 1) * w + c];
        x.last = (r == h - 2) && (c == w - 2);
        exp_q.push_back(x);
      end
    end
  endtask

  // Stream pix_q into one DUT, collecting consumed windows.
  task automatic run(input bit sel, input bit drain, input bit stall);
    int i, sl, cyc, n;
    bit ds, v, rd, irdy;
    win_t w;
    i   = 0;
    sl  = 0;
    cyc = 0;
    ds  = 0;
    n   = pix_q.size();
    while ((i < n || (drain && ovld(sel))) && cyc < 5000) begin
      if (stall && !ds && got_q.size() == 1 && ovld(sel)) begin
        sl = 3;
        ds = 1;
      end
      v  = (i < n) && (!sel || $urandom_range(0, 9) < 7);
      rd = (sl == 0) && (!sel || $urandom_range(0, 9) < 7);
      drive(sel, v, (i < n) ? pix_q[i] : 8'h00, rd);
      #1;
      irdy = sel ? r_if.in_ready : s_if.in_ready;
      w    = sel ? win_r : win_s;
      if (sel) chk("ready_rule", irdy, !ovld(sel) || rd);
      if (sl > 0) begin
        chk("stall_in_ready", irdy, 0);
        chk("stall_hold", w, exp_q[1]);
        sl--;
      end
      if (v && irdy) i++;
      if (ovld(sel) && rd) got_q.push_back(w);
      @(negedge clk);
      cyc++;
    end
    drive(sel, 1'b0, 8'h00, 1'b1);
    if (cyc >= 5000) chk("timeout", 1, 0);
  endtask

  task automatic cmp(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk(tag, got_q[k], exp_q[k]);
  endtask

  task automatic load_seq(input int base, input int n);
    for (int k = 0; k < n; k++) pix_q.push_back(8'(base + k));
  endtask

  task automatic clear_all();
    pix_q.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    win_t x;
    int nl;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("rst_win_s", win_s, 0);
    chk("rst_vld_s", s_if.out_valid, 0);
    chk("rst_win_r", win_r, 0);
    chk("rst_vld_r", r_if.out_valid, 0);
    chk("rst_rdy_s", s_if.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    clear_all();
    load_seq(0, 16);
    model(4, 4, 0);
    run(1'b0, 1'b1, 1'b0);
    cmp("basic");
    if (got_q.size() == 4) begin
      x = '{8'd1, 8'd4, 8'd5, 8'd6, 8'd9, 1'b0};
      chk("basic_w1", got_q[0], x);
      x = '{8'd6, 8'd9, 8'd10, 8'd11, 8'd14, 1'b1};
      chk("basic_w4", got_q[3], x);
    end

    clear_all();
    load_seq(0, 16);
    model(4, 4, 0);
    run(1'b0, 1'b1, 1'b1);
    cmp("stall");
    x = '{8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 1'b0};
    chk("stall_w2_ref", exp_q[1], x);

    clear_all();
    load_seq(0, 16);
    load_seq(100, 16);
    model(4, 4, 0);
    model(4, 4, 16);
    run(1'b0, 1'b1, 1'b0);
    cmp("b2b");
    if (got_q.size() == 8) begin
      x = '{8'd101, 8'd104, 8'd105, 8'd106, 8'd109, 1'b0};
      chk("b2b_f2w1", got_q[4], x);
    end

    clear_all();
    load_seq(0, 11);
    run(1'b0, 1'b0, 1'b0);
    chk("pre_rst_vld", s_if.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", s_if.out_valid, 0);
    chk("mid_rst_win", win_s, 0);
    @(negedge clk);
    chk("mid_rst_win2", win_s, 0);
    rst_n = 1'b1;
    @(negedge clk);
    clear_all();
    load_seq(0, 16);
    model(4, 4, 0);
    run(1'b0, 1'b1, 1'b0);
    cmp("after_rst");

    clear_all();
    for (int k = 0; k < 3 * 48; k++) pix_q.push_back(8'($urandom));
    for (int fr = 0; fr < 3; fr++) model(8, 6, fr * 48);
    run(1'b1, 1'b1, 1'b0);
    cmp("rand");
    nl = 0;
    foreach (got_q[k]) if (got_q[k].last) nl++;
    chk("rand_last_count", nl, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
